// File: rtl/game_control.sv
// game_control
// Match sequencer for a two-player paddle game. It turns the start button and
// the goal sensors into a serve / play / game-over flow, keeps both scores and
// reports the winner.
//
// Parameters
//   TICK_DIV    : clk cycles per game tick
//   SERVE_DELAY : game ticks the ball is held at centre before each serve (2..65535)
//   WIN_SCORE   : points needed to win the match (1..15)
//
// Ports
//   clk         : system clock, all logic on the rising edge
//   rst         : asynchronous, active-low reset
//   start       : player start button (level, synchronous to clk)
//   goal        : 2'b11 left goal hit (right scores), 2'b10 right goal hit (left scores)
//   state       : 1 while the ball is in play, 0 while it is held at centre
//   adv         : serve control, adv[1] forces direction, adv[0]=1 serves leftward
//   score_left  : left player's points
//   score_right : right player's points
//   winner      : 2'b00 none, 2'b10 left won, 2'b11 right won

module game_control #(
   parameter int TICK_DIV    = 220000,
   parameter int SERVE_DELAY = 1000,
   parameter int WIN_SCORE   = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] goal,
   output logic       state,
   output logic [1:0] adv,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic [1:0] winner
);

   localparam int              TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [15:0]     SERVE_LAST = 16'(SERVE_DELAY - 1);
   localparam logic [3:0]      WIN_VAL    = 4'(WIN_SCORE);

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      PLAY,
      OVER
   } fsm_t;

   fsm_t        fsm;
   fsm_t        fsm_next;

   logic [TW-1:0] tick_cnt;
   logic          tick;

   logic [15:0] serve_cnt;
   logic [15:0] serve_cnt_next;

   logic        start_prev;
   logic        start_armed;
   logic        goal_prev_hit;
   logic        start_ev;
   logic        goal_ev;

   logic [1:0]  adv_next;
   logic [1:0]  winner_next;
   logic [3:0]  score_left_next;
   logic [3:0]  score_right_next;
   logic [3:0]  left_inc;
   logic [3:0]  right_inc;

   // Free-running tick divider. It is never re-phased by the game flow, so a
   // serve may see its first tick anywhere from one to TICK_DIV clocks after
   // it begins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   // Edge detection on the buttons and goal sensors. start_armed only sets
   // once start has been seen low, so a button still held down when reset is
   // released cannot launch a game; the player must let go and press again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_prev    <= 1'b0;
         start_armed   <= 1'b0;
         goal_prev_hit <= 1'b0;
      end else begin
         start_prev    <= start;
         start_armed   <= start_armed | ~start;
         goal_prev_hit <= goal[1];
      end
   end

   // A goal is any code with the top bit set (10 or 11); moving straight from
   // one goal code to the other is still the same held contact, not a new event.
   assign start_ev  = start & ~start_prev & start_armed;
   assign goal_ev   = goal[1] & ~goal_prev_hit;
   assign left_inc  = score_left + 4'd1;
   assign right_inc = score_right + 4'd1;

   // Next-state and next-output logic for the match flow.
   always_comb begin
      fsm_next         = fsm;
      serve_cnt_next   = serve_cnt;
      adv_next         = adv;
      winner_next      = winner;
      score_left_next  = score_left;
      score_right_next = score_right;

      case (fsm)
         IDLE, OVER: begin
            if (start_ev) begin
               score_left_next  = 4'd0;
               score_right_next = 4'd0;
               adv_next         = 2'b00;
               winner_next      = 2'b00;
               serve_cnt_next   = 16'd0;
               fsm_next         = SERVE;
            end
         end

         SERVE: begin
            if (tick) begin
               if (serve_cnt == SERVE_LAST) begin
                  fsm_next = PLAY;
               end else begin
                  serve_cnt_next = serve_cnt + 16'd1;
               end
            end
         end

         PLAY: begin
            if (goal_ev) begin
               if (goal[0]) begin
                  score_right_next = right_inc;
                  if (right_inc == WIN_VAL) begin
                     winner_next = 2'b11;
                     fsm_next    = OVER;
                  end else begin
                     adv_next       = 2'b11;
                     serve_cnt_next = 16'd0;
                     fsm_next       = SERVE;
                  end
               end else begin
                  score_left_next = left_inc;
                  if (left_inc == WIN_VAL) begin
                     winner_next = 2'b10;
                     fsm_next    = OVER;
                  end else begin
                     adv_next       = 2'b10;
                     serve_cnt_next = 16'd0;
                     fsm_next       = SERVE;
                  end
               end
            end
         end

         default: begin
            fsm_next = IDLE;
         end
      endcase
   end

   // Match registers. The ball-in-play flag follows the registered FSM, so it
   // lags the state change by one clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm         <= IDLE;
         serve_cnt   <= 16'd0;
         adv         <= 2'b00;
         winner      <= 2'b00;
         score_left  <= 4'd0;
         score_right <= 4'd0;
         state       <= 1'b0;
      end else begin
         fsm         <= fsm_next;
         serve_cnt   <= serve_cnt_next;
         adv         <= adv_next;
         winner      <= winner_next;
         score_left  <= score_left_next;
         score_right <= score_right_next;
         state       <= (fsm == PLAY);
      end
   end

endmodule

// File: tb/tb_game_control.sv
// tb_game_control
// Self-checking bench for game_control with TICK_DIV=4, SERVE_DELAY=3,
// WIN_SCORE=3. A behavioural model of the match rules follows the DUT every
// clock; a table of scripted steps and a few hand sequences add fixed
// expectations for the scenarios that matter most.

module tb_game_control;

   localparam int TICK_DIV    = 4;
   localparam int SERVE_DELAY = 3;
   localparam int WIN_SCORE   = 3;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       start = 1'b0;
   logic [1:0] goal  = 2'b00;

   logic       state;
   logic [1:0] adv;
   logic [3:0] score_left;
   logic [3:0] score_right;
   logic [1:0] winner;

   int checks = 0;
   int errors = 0;

   game_control #(
      .TICK_DIV    (TICK_DIV),
      .SERVE_DELAY (SERVE_DELAY),
      .WIN_SCORE   (WIN_SCORE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .goal        (goal),
      .state       (state),
      .adv         (adv),
      .score_left  (score_left),
      .score_right (score_right),
      .winner      (winner)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 60)
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive inputs (caller sits just after a falling edge), let n rising edges
   // pass, and return just after the following falling edge.
   task automatic applyStimulus(input bit s, input logic [1:0] g, input int n);
      start = s;
      goal  = g;
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: the match is "waiting", "serving" or "playing";
   // a serve counts down whole ticks; a tick is every TICK_DIV-th clock
   // since reset release; the in-play flag is the playing flag one clock late.
   // ------------------------------------------------------------------
   bit         m_valid = 1'b0;
   int         m_cycle;
   bit         m_armed, m_pstart, m_pgoal;
   bit         m_serving, m_playing;
   int         m_serve_left;
   bit         m_state;
   logic [1:0] m_adv, m_winner;
   int         m_lp, m_rp;
   bit         m_tick, m_sev, m_gev, m_hit;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_cycle      = 0;
         m_armed      = 1'b0;
         m_pstart     = 1'b0;
         m_pgoal      = 1'b0;
         m_serving    = 1'b0;
         m_playing    = 1'b0;
         m_serve_left = 0;
         m_state      = 1'b0;
         m_adv        = 2'b00;
         m_winner     = 2'b00;
         m_lp         = 0;
         m_rp         = 0;
         m_valid      = 1'b1;
      end else begin
         m_tick   = (m_cycle % TICK_DIV) == TICK_DIV - 1;
         m_cycle++;
         m_hit    = (goal == 2'b10) || (goal == 2'b11);
         m_sev    = start && !m_pstart && m_armed;
         m_gev    = m_hit && !m_pgoal;
         m_armed  = m_armed || !start;
         m_pstart = start;
         m_pgoal  = m_hit;
         m_state  = m_playing;
         if (m_playing) begin
            if (m_gev) begin
               m_playing = 1'b0;
               if (goal == 2'b11) begin
                  m_rp++;
                  if (m_rp == WIN_SCORE) m_winner = 2'b11;
                  else begin
                     m_adv        = 2'b11;
                     m_serving    = 1'b1;
                     m_serve_left = SERVE_DELAY;
                  end
               end else begin
                  m_lp++;
                  if (m_lp == WIN_SCORE) m_winner = 2'b10;
                  else begin
                     m_adv        = 2'b10;
                     m_serving    = 1'b1;
                     m_serve_left = SERVE_DELAY;
                  end
               end
            end
         end else if (m_serving) begin
            if (m_tick) begin
               m_serve_left--;
               if (m_serve_left == 0) begin
                  m_serving = 1'b0;
                  m_playing = 1'b1;
               end
            end
         end else if (m_sev) begin
            m_lp         = 0;
            m_rp         = 0;
            m_adv        = 2'b00;
            m_winner     = 2'b00;
            m_serving    = 1'b1;
            m_serve_left = SERVE_DELAY;
         end
      end
   end

   // Compare every output against the model on each falling edge.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         checkOutput("model_state",  int'(state),       int'(m_state));
         checkOutput("model_adv",    int'(adv),         int'(m_adv));
         checkOutput("model_left",   int'(score_left),  m_lp);
         checkOutput("model_right",  int'(score_right), m_rp);
         checkOutput("model_winner", int'(winner),      int'(m_winner));
      end
   end

   // Scripted steps: inputs, clocks to hold them, outputs expected afterwards.
   typedef struct {
      bit         s;
      logic [1:0] g;
      int         n;
      bit         e_state;
      logic [1:0] e_adv;
      int         e_left;
      int         e_right;
      logic [1:0] e_win;
   } vec_t;

   vec_t vecs[14];

   task automatic checkAll(input string tag, input bit e_state, input logic [1:0] e_adv,
                           input int e_left, input int e_right, input logic [1:0] e_win);
      checkOutput({tag, "_state"},  int'(state),       int'(e_state));
      checkOutput({tag, "_adv"},    int'(adv),         int'(e_adv));
      checkOutput({tag, "_left"},   int'(score_left),  e_left);
      checkOutput({tag, "_right"},  int'(score_right), e_right);
      checkOutput({tag, "_winner"}, int'(winner),      int'(e_win));
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   initial begin
      // idle, start a game, serve, first play period
      vecs[0]  = '{1'b0, 2'b00,  4, 1'b0, 2'b00, 0, 0, 2'b00};
      vecs[1]  = '{1'b1, 2'b00,  2, 1'b0, 2'b00, 0, 0, 2'b00};
      vecs[2]  = '{1'b0, 2'b00, 16, 1'b1, 2'b00, 0, 0, 2'b00};
      // held left-goal contact scores once and reserves toward the left
      vecs[3]  = '{1'b0, 2'b11, 20, 1'b1, 2'b11, 0, 1, 2'b00};
      vecs[4]  = '{1'b0, 2'b00,  2, 1'b1, 2'b11, 0, 1, 2'b00};
      // left player scores three times, each in its own play period
      vecs[5]  = '{1'b0, 2'b10,  2, 1'b0, 2'b10, 1, 1, 2'b00};
      vecs[6]  = '{1'b0, 2'b00, 16, 1'b1, 2'b10, 1, 1, 2'b00};
      vecs[7]  = '{1'b0, 2'b10,  2, 1'b0, 2'b10, 2, 1, 2'b00};
      vecs[8]  = '{1'b0, 2'b00, 16, 1'b1, 2'b10, 2, 1, 2'b00};
      vecs[9]  = '{1'b0, 2'b10,  2, 1'b0, 2'b10, 3, 1, 2'b10};
      vecs[10] = '{1'b0, 2'b00, 16, 1'b0, 2'b10, 3, 1, 2'b10};
      // goal after game over is ignored
      vecs[11] = '{1'b0, 2'b11,  4, 1'b0, 2'b10, 3, 1, 2'b10};
      // restart from game over clears everything
      vecs[12] = '{1'b1, 2'b00,  2, 1'b0, 2'b00, 0, 0, 2'b00};
      vecs[13] = '{1'b0, 2'b00, 16, 1'b1, 2'b00, 0, 0, 2'b00};

      // Reset values while held in reset.
      repeat (3) @(negedge clk);
      checkAll("reset", 1'b0, 2'b00, 0, 0, 2'b00);
      #1 rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].s, vecs[i].g, vecs[i].n);
         checkAll($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_adv,
                  vecs[i].e_left, vecs[i].e_right, vecs[i].e_win);
      end

      // Reset in the middle of play with left on 2 points, start held through release.
      applyStimulus(1'b0, 2'b10, 2);
      applyStimulus(1'b0, 2'b00, 16);
      applyStimulus(1'b0, 2'b10, 2);
      applyStimulus(1'b0, 2'b00, 16);
      checkAll("preabort", 1'b1, 2'b10, 2, 0, 2'b00);
      start = 1'b1;
      rst   = 1'b0;
      #1;
      checkAll("async_reset", 1'b0, 2'b00, 0, 0, 2'b00);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      applyStimulus(1'b1, 2'b00, 30);
      checkAll("held_start", 1'b0, 2'b00, 0, 0, 2'b00);
      applyStimulus(1'b0, 2'b00, 2);
      applyStimulus(1'b1, 2'b00, 16);
      checkAll("restart", 1'b1, 2'b00, 0, 0, 2'b00);

      // Non-goal code and a goal during serve change nothing.
      applyStimulus(1'b0, 2'b10, 2);
      checkAll("to_serve", 1'b0, 2'b10, 1, 0, 2'b00);
      applyStimulus(1'b0, 2'b01, 2);
      checkAll("serve_g01", 1'b0, 2'b10, 1, 0, 2'b00);
      applyStimulus(1'b0, 2'b00, 1);
      applyStimulus(1'b0, 2'b11, 2);
      checkAll("serve_g11", 1'b0, 2'b10, 1, 0, 2'b00);
      applyStimulus(1'b0, 2'b00, 16);
      checkAll("after_serve", 1'b1, 2'b10, 1, 0, 2'b00);

      // Randomized play against the model, with occasional resets.
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 99) < 3) begin
            rst   = 1'b0;
            start = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk);
            #1 rst = 1'b1;
         end else begin
            applyStimulus(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          int'($urandom_range(1, 8)));
         end
      end

      applyStimulus(1'b0, 2'b00, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
